// File: rtl/memory_access_if.sv
// Bundle of execute-side, data-memory and write-back-side signals
// for the memory-access stage.
interface memory_access_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [31:0] data_out;
    logic [31:0] mem_data_out;
    logic        err_out;

    modport slave (
        input  in_valid, instruction_in, alu_result_in, store_data_in,
        input  mem_ack, mem_rdata, out_ready,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output out_valid, instruction_out, data_out, mem_data_out,
        output err_out
    );

    modport master (
        output in_valid, instruction_in, alu_result_in, store_data_in,
        output mem_ack, mem_rdata, out_ready,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  out_valid, instruction_out, data_out, mem_data_out,
        input  err_out
    );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: LW/SW req/ack transaction with timeout,
// other opcodes pass straight to the output register.
module memory_access #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clock,
    input logic              reset_n,
    memory_access_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] mdata_q, mdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        in_ready_w;
    logic        accept;
    logic        in_mem;
    logic        is_lw_q;
    logic        is_sw_q;

    assign in_ready_w = (state_q == IDLE) |
                        ((state_q == OUT) & bus.out_ready);
    assign accept  = bus.in_valid & in_ready_w;
    assign in_mem  = (bus.instruction_in[31:27] <= 5'd1);
    assign is_lw_q = (instr_q[31:27] == 5'd0);
    assign is_sw_q = (instr_q[31:27] == 5'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            alu_q   <= '0;
            sdata_q <= '0;
            mdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            alu_q   <= alu_d;
            sdata_q <= sdata_d;
            mdata_q <= mdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        alu_d   = alu_q;
        sdata_d = sdata_q;
        mdata_d = mdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: ;
            REQ: begin
                // ack in the final wait cycle beats the timeout
                if (bus.mem_ack) begin
                    mdata_d = is_lw_q ? bus.mem_rdata : 32'h0;
                    err_d   = 1'b0;
                    state_d = OUT;
                end else if (cnt_q == LAST) begin
                    mdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            instr_d = bus.instruction_in;
            alu_d   = bus.alu_result_in;
            sdata_d = bus.store_data_in;
            mdata_d = 32'h0;
            err_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = in_mem ? REQ : OUT;
        end
    end

    always_comb begin
        bus.in_ready        = in_ready_w;
        bus.mem_req         = (state_q == REQ);
        bus.mem_we          = is_sw_q;
        bus.mem_addr        = {alu_q[31:2], 2'b00};
        bus.mem_wdata       = is_sw_q ? sdata_q : 32'h0;
        bus.out_valid       = (state_q == OUT);
        bus.instruction_out = instr_q;
        bus.data_out        = alu_q;
        bus.mem_data_out    = mdata_q;
        bus.err_out         = err_q;
    end
endmodule

// File: tb/tb_memory_access.sv
// Directed, table-driven bench for memory_access (TIMEOUT_CYCLES=4).
// Expected values are hand-computed per vector.
module tb_memory_access;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    memory_access_if bus();

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] alu;
        logic [31:0] sdata;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_req;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid       = 1'b0;
        bus.instruction_in = '0;
        bus.alu_result_in  = '0;
        bus.store_data_in  = '0;
        bus.mem_ack        = 1'b0;
        bus.mem_rdata      = '0;
        bus.out_ready      = 1'b1;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] ins;
        int          n;
        v   = vecs[i];
        ins = {v.op, 27'h0ABCDEF};
        @(negedge clk);
        bus.in_valid       = 1'b1;
        bus.instruction_in = ins;
        bus.alu_result_in  = v.alu;
        bus.store_data_in  = v.sdata;
        bus.mem_rdata      = v.rdata;
        bus.out_ready      = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        for (int c = 1; c <= 20 && bus.mem_req; c++) begin
            if (c == 1) begin
                chk($sformatf("v%0d we", i), 32'(bus.mem_we), 32'(v.exp_we));
                chk($sformatf("v%0d wdata", i), bus.mem_wdata, v.exp_wdata);
                chk($sformatf("v%0d in_ready_req", i),
                    32'(bus.in_ready), 32'd0);
            end
            chk($sformatf("v%0d addr c%0d", i, c), bus.mem_addr, v.exp_addr);
            bus.mem_ack = (c == v.ack_at);
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            n++;
        end
        if (bus.mem_req) chk($sformatf("v%0d req_bound", i), 32'd1, 32'd0);
        chk($sformatf("v%0d req_cycles", i), 32'(n), 32'(v.exp_req));
        chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
        chk($sformatf("v%0d mdata", i), bus.mem_data_out, v.exp_mdata);
        chk($sformatf("v%0d err", i), 32'(bus.err_out), 32'(v.exp_err));
        chk($sformatf("v%0d data_out", i), bus.data_out, v.alu);
        chk($sformatf("v%0d instr_out", i), bus.instruction_out, ins);
        @(posedge clk); #1;
        chk($sformatf("v%0d retired", i), 32'(bus.out_valid), 32'd0);
        chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{5'd2,  32'h0000_1234, 32'h0, 0, 32'h0,
                    0, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{5'd0,  32'h0000_0103, 32'h0, 3, 32'hDEAD_BEEF,
                    3, 32'h0000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{5'd1,  32'h0000_0040, 32'hCAFE_F00D, 1, 32'h1111_1111,
                    1, 32'h0000_0040, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[3] = '{5'd0,  32'h0000_0200, 32'h0, 0, 32'h7777_7777,
                    4, 32'h0000_0200, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[4] = '{5'd0,  32'h0000_0300, 32'h0, 4, 32'h1234_5678,
                    4, 32'h0000_0300, 1'b0, 32'h0, 32'h1234_5678, 1'b0};
        vecs[5] = '{5'd1,  32'h0000_0402, 32'hAAAA_0001, 0, 32'h0,
                    4, 32'h0000_0400, 1'b1, 32'hAAAA_0001, 32'h0, 1'b1};
        vecs[6] = '{5'd31, 32'hFFFF_FFFF, 32'h0000_0005, 0, 32'h0,
                    0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[7] = '{5'd0,  32'hFFFF_FFFF, 32'h0, 2, 32'hA5A5_A5A5,
                    2, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst data_out", bus.data_out, 32'h0);
        chk("rst mdata", bus.mem_data_out, 32'h0);
        chk("rst err", 32'(bus.err_out), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // backpressure, then retire + accept in the same cycle
        @(negedge clk);
        bus.out_ready      = 1'b0;
        bus.in_valid       = 1'b1;
        bus.instruction_in = {5'd2, 27'h1};
        bus.alu_result_in  = 32'h0000_00AA;
        @(posedge clk); #1;
        bus.in_valid       = 1'b0;
        bus.alu_result_in  = 32'h0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp data c%0d", c), bus.data_out, 32'h0000_00AA);
            chk($sformatf("bp in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.out_ready      = 1'b1;
        bus.in_valid       = 1'b1;
        bus.instruction_in = {5'd3, 27'h2};
        bus.alu_result_in  = 32'h0000_0055;
        #1;
        chk("b2b in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b out_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b data", bus.data_out, 32'h0000_0055);
        chk("b2b instr", bus.instruction_out, {5'd3, 27'h2});
        @(posedge clk); #1;
        chk("b2b idle", 32'(bus.out_valid), 32'd0);

        // reset in the middle of a pending LW
        @(negedge clk);
        bus.in_valid       = 1'b1;
        bus.instruction_in = {5'd0, 27'h3};
        bus.alu_result_in  = 32'h0000_0500;
        bus.mem_rdata      = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid req up", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid req async drop", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("late ack out_valid", 32'(bus.out_valid), 32'd0);
        chk("late ack mem_req", 32'(bus.mem_req), 32'd0);
        chk("late ack mdata", bus.mem_data_out, 32'h0);
        @(posedge clk); #1;
        chk("post rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("post rst out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
